// File: rtl/u712_pkg.sv
// U712 shared definitions: capture FSM states, DMA timeout default,
// C7 phase saturation and the synchronized control bundle.
package u712_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ROW     = 3'd1,
    S_REQ     = 3'd2,
    S_BUSY    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam int ACK_TIMEOUT_DEF = 40;
  localparam logic [3:0] C7_SAT = 4'd15;

  typedef struct packed {
    logic ras0;
    logic ras1;
    logic casl;
    logic casu;
    logic awe;
    logic clk7;
  } ctl_t;

  // Idle level of each control bit, same order as ctl_t
  localparam logic [5:0] CTL_RST = 6'b111110;

  function automatic logic [3:0] c7_next(input logic [3:0] p);
    return (p == C7_SAT) ? C7_SAT : p + 4'd1;
  endfunction

endpackage

// File: rtl/u712_sync2.sv
// Two-flop synchronizer for one asynchronous bit into CLK80,
// reset to the bit's idle level.
module u712_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/u712_agnus_capture.sv
// Agnus DMA capture: watches Agnus RAS/CAS/DRA and turns each
// chip RAM access into a DMA request on the CLK80 domain.
module u712_agnus_capture
  import u712_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic       CLK80,
  input  logic       RESET,
  input  logic       nRAS0,
  input  logic       nRAS1,
  input  logic       nCASL,
  input  logic       nCASU,
  input  logic       nAWE,
  input  logic       CLK7,
  input  logic [9:0] DRA,
  input  logic       DMA_ACK,
  input  logic       DMA_DONE,
  output logic       DMA_REQ,
  output logic       RAS_PENDING,
  output logic       AGNUS_REFRESH,
  output logic [9:0] DMA_ROW,
  output logic [8:0] DMA_COL,
  output logic       DMA_LOWBYTE,
  output logic       DMA_WRITE,
  output logic       DMA_ABORT,
  output logic       DMA_OVERRUN,
  output logic [3:0] C7_PHASE
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [4:0] HIST_RST = 5'b11110;

  logic [5:0] raw_v;
  logic [5:0] sync_v;
  ctl_t       s;

  assign raw_v = {nRAS0, nRAS1, nCASL, nCASU, nAWE, CLK7};

  for (genvar i = 0; i < 6; i++) begin : g_sync
    u712_sync2 #(
      .RST_VAL(CTL_RST[i])
    ) u_sync (
      .clk(CLK80),
      .rst(RESET),
      .d  (raw_v[i]),
      .q  (sync_v[i])
    );
  end

  assign s = ctl_t'(sync_v);

  state_t         state_q, state_d;
  logic [4:0]     hist_q, hist_d;
  logic [9:0]     dra1_q, dra1_d;
  logic [9:0]     dra2_q, dra2_d;
  logic [9:0]     row_q, row_d;
  logic [8:0]     col_q, col_d;
  logic           lb_q, lb_d;
  logic           wr_q, wr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           abort_q, abort_d;
  logic           ovr_q, ovr_d;
  logic           refresh_q, refresh_d;
  logic [3:0]     c7_q, c7_d;

  logic h_ras0, h_ras1, h_casl, h_casu, h_clk7;
  assign {h_ras0, h_ras1, h_casl, h_casu, h_clk7} = hist_q;

  logic ras0_lo2, ras1_lo2;
  logic ras_valid, refresh_valid, cas_valid;
  logic ras_off, all_high, c7_rise;

  // Qualifiers need two consecutive synchronized samples
  always_comb begin
    ras0_lo2      = ~s.ras0 & ~h_ras0;
    ras1_lo2      = ~s.ras1 & ~h_ras1;
    ras_valid     = (ras0_lo2 & s.ras1 & h_ras1)
                  | (ras1_lo2 & s.ras0 & h_ras0);
    refresh_valid = ras0_lo2 & ras1_lo2;
    cas_valid     = (~s.casl & ~h_casl) | (~s.casu & ~h_casu);
    ras_off       = s.ras0 & s.ras1;
    all_high      = ras_off & s.casl & s.casu;
    c7_rise       = s.clk7 & ~h_clk7;
  end

  always_ff @(posedge CLK80 or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    lb_d    = lb_q;
    wr_d    = wr_q;
    cnt_d   = '0;
    abort_d = 1'b0;
    ovr_d   = ovr_q;
    unique case (state_q)
      S_IDLE: begin
        if (ras_valid) begin
          state_d = S_ROW;
          row_d   = {s.ras0, dra2_q[8:0]};
        end
      end
      S_ROW: begin
        if (ras_off) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else if (cas_valid) begin
          state_d = S_REQ;
          col_d   = dra2_q[9:1];
          lb_d    = dra2_q[0];
          wr_d    = ~s.awe;
        end
      end
      S_REQ: begin
        if (DMA_ACK) begin
          state_d = S_BUSY;
        end else if (ras_off) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == TO_LAST) begin
          ovr_d   = 1'b1;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BUSY: begin
        if (DMA_DONE) begin
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (all_high) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    DMA_REQ     = 1'b0;
    RAS_PENDING = 1'b0;
    unique case (state_q)
      S_ROW, S_BUSY: RAS_PENDING = 1'b1;
      S_REQ: begin
        DMA_REQ     = 1'b1;
        RAS_PENDING = 1'b1;
      end
      default: ;
    endcase
  end

  // DRA is delayed to line up with the synchronized strobes
  always_comb begin
    hist_d    = {s.ras0, s.ras1, s.casl, s.casu, s.clk7};
    dra1_d    = DRA;
    dra2_d    = dra1_q;
    refresh_d = refresh_valid;
    c7_d      = c7_rise ? 4'd0 : c7_next(c7_q);
  end

  always_ff @(posedge CLK80 or posedge RESET) begin
    if (RESET) begin
      hist_q    <= HIST_RST;
      dra1_q    <= '0;
      dra2_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      lb_q      <= 1'b0;
      wr_q      <= 1'b0;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      ovr_q     <= 1'b0;
      refresh_q <= 1'b0;
      c7_q      <= '0;
    end else begin
      hist_q    <= hist_d;
      dra1_q    <= dra1_d;
      dra2_q    <= dra2_d;
      row_q     <= row_d;
      col_q     <= col_d;
      lb_q      <= lb_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
      ovr_q     <= ovr_d;
      refresh_q <= refresh_d;
      c7_q      <= c7_d;
    end
  end

  assign AGNUS_REFRESH = refresh_q;
  assign DMA_ROW       = row_q;
  assign DMA_COL       = col_q;
  assign DMA_LOWBYTE   = lb_q;
  assign DMA_WRITE     = wr_q;
  assign DMA_ABORT     = abort_q;
  assign DMA_OVERRUN   = ovr_q;
  assign C7_PHASE      = c7_q;

endmodule
